// File: rtl/vga_timing_gen_if.sv
// Video timing bus between vga_timing_gen (master) and its pixel consumer (slave).
// Optional test-pattern signal tp_rgb is present only with VGA_TG_TESTPAT_EN defined.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          restart;
    logic          hs;
    logic          vs;
    logic          de;
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_TG_TESTPAT_EN
    logic [23:0]   tp_rgb;
`endif

    modport master (
        input  restart,
        output hs, vs, de, req, x, y, line_start, frame_start
`ifdef VGA_TG_TESTPAT_EN
        , output tp_rgb
`endif
    );

    modport slave (
        output restart,
        input  hs, vs, de, req, x, y, line_start, frame_start
`ifdef VGA_TG_TESTPAT_EN
        , input tp_rgb
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters with registered sync,
// active-video enable, one-cycle-early fetch request, pixel coordinates and
// line/frame start strobes. Line order is sync, back porch, display, front porch.
// Optional macro VGA_TG_TESTPAT_EN adds an 8-bar colour test pattern on tp_rgb.
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CW      = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_timing_gen_if.master   bus
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BACK + V_DISP);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          act_now, act_next;

    logic          hs_q, vs_q, de_q, req_q, ls_q, fs_q;
    logic [CW-1:0] x_q, y_q;

    function automatic logic in_active(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return (h >= H_ACT_BEG) && (h < H_ACT_END) && (v >= V_ACT_BEG) && (v < V_ACT_END);
    endfunction

    // Counter next state; restart overrides the normal wrap.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
        if (bus.restart) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    // Active-region decode for the current and the upcoming counter state.
    always_comb begin
        act_now  = in_active(hcnt_q, vcnt_q);
        act_next = in_active(hcnt_d, vcnt_d);
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Registered outputs, one clock behind the counters; req is decoded from
    // the next counter state so it leads de by exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            req_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            hs_q  <= (hcnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
            vs_q  <= (vcnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
            de_q  <= act_now;
            req_q <= act_next;
            ls_q  <= (hcnt_q == '0);
            fs_q  <= (hcnt_q == '0) && (vcnt_q == '0);
            x_q   <= act_now ? hcnt_q - H_ACT_BEG : '0;
            y_q   <= act_now ? vcnt_q - V_ACT_BEG : '0;
        end
    end

    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.de          = de_q;
    assign bus.req         = req_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;

`ifdef VGA_TG_TESTPAT_EN
    localparam int BAR_W = (H_DISP >= 8) ? H_DISP / 8 : 1;

    logic [CW-1:0] hx;
    int            bar_idx;
    logic [2:0]    bar;
    logic [23:0]   tp_d, tp_q;

    // Bar colour from horizontal position. Bars 0..7 are white, yellow, cyan,
    // green, magenta, red, blue, black: R = ~bar[1], G = ~bar[2], B = ~bar[0].
    // Leftover pixels when H_DISP is not a multiple of 8 stay in the last bar.
    always_comb begin
        hx      = hcnt_q - H_ACT_BEG;
        bar_idx = int'(hx) / BAR_W;
        bar     = (bar_idx > 7) ? 3'd7 : bar_idx[2:0];
        tp_d    = '0;
        if (act_now) begin
            tp_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        end
    end

    // Test-pattern register, aligned with de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q <= '0;
        end else begin
            tp_q <= tp_d;
        end
    end

    assign bus.tp_rgb = tp_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: horizontal sync width, pixel clocks.
REQ-002 SHALL have parameter H_BACK, default 48: horizontal back porch.
REQ-003 SHALL have parameter H_DISP, default 640: active pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 16: horizontal front porch.
REQ-005 SHALL have parameters V_SYNC 2, V_BACK 33, V_DISP 480, V_FRONT 10: vertical equivalents, in lines.
REQ-006 SHALL have parameter HS_POL, default 0: active level of hs. SHALL have parameter VS_POL, default 0: active level of vs.
REQ-007 SHALL have parameter CW, default 12: width of counters and coordinates.
REQ-008 clk  in  1  pixel clock.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 restart  in  1  synchronous frame restart.
REQ-011 hs, vs  out  1 each  sync outputs, polarity per HS_POL and VS_POL.
REQ-012 de  out  1  active-video enable.
REQ-013 req  out  1  pixel fetch request, one cycle ahead of de.
REQ-014 x, y  out  CW each  active pixel coordinates.
REQ-015 line_start, frame_start  out  1 each  single-cycle strobes.

Function
REQ-016 SHALL derive H_TOTAL as H_SYNC+H_BACK+H_DISP+H_FRONT and V_TOTAL as the vertical equivalent.
REQ-017 hcnt SHALL count 0..H_TOTAL-1 and wrap to 0. vcnt SHALL increment on the hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-018 Line order SHALL be sync, back porch, display, front porch. hs SHALL be active while hcnt<H_SYNC, and vs SHALL be active while vcnt<V_SYNC.
REQ-019 Active region: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-020 hs, vs, de, x, y, line_start and frame_start SHALL all be registered with a fixed latency of 1 clk from their counter state, and SHALL be mutually aligned.
REQ-021 While de=1, x SHALL run 0..H_DISP-1 and y SHALL run 0..V_DISP-1; outside the active region both SHALL be 0.
REQ-022 req SHALL equal de advanced by exactly 1 clk: H_DISP req cycles per active line, with none on blanking lines.
REQ-023 line_start SHALL pulse for the output cycle of hcnt=0. frame_start SHALL pulse for the output cycle of hcnt=0 with vcnt=0.
REQ-024 restart=1 SHALL force hcnt=vcnt=0 on the next edge. restart SHALL take priority over a simultaneous wrap.
REQ-025 Holding restart high SHALL hold the counters at 0, so frame_start and line_start repeat every cycle.
REQ-026 No output SHALL glitch or contain a combinational path from restart.

Reset
REQ-027 On rst_n=0: hcnt, vcnt, x, y = 0; de, req, line_start, frame_start = 0; hs = ~HS_POL; vs = ~VS_POL.
REQ-028 An asserted rst_n mid-frame SHALL abort the frame immediately. After release, the first output cycle SHALL be frame_start with hs and vs active.

Configuration
REQ-029 With macro VGA_TG_TESTPAT_EN defined, the block SHALL add output tp_rgb [23:0]: 8 equal vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_DISP/8 pixels wide.
REQ-030 tp_rgb SHALL be aligned with de and SHALL be 0 while de=0.
REQ-031 Without VGA_TG_TESTPAT_EN, the tp_rgb port and its logic SHALL be absent. All other behaviour SHALL be identical with and without the macro.

Verification
Bench parameters: H 2/3/8/1 (H_TOTAL 14), V 1/1/4/1 (V_TOTAL 7), HS_POL=0, VS_POL=0.
REQ-032 Release reset, run 2 frames -> frame_start every 98 clks; hs low 2 of every 14 clks; vs low 14 clks per frame.
REQ-033 Active line -> req high 8 clks, de high 8 clks starting 1 clk later, x 0..7; y 0..3 over lines 2..5; de never high on lines 0, 1 or 6.
REQ-034 restart pulse at hcnt=9, vcnt=3 -> 2 clks later, frame_start=1, hs=0, vs=0, de=0.
REQ-035 restart asserted on the wrap cycle (hcnt=13, vcnt=6) -> counters 0 next clk; exactly one frame_start.
REQ-036 rst_n low at hcnt=5, vcnt=2 -> outputs immediately at reset values; after release, frame period again 98.
REQ-037 With VGA_TG_TESTPAT_EN -> tp_rgb: x=0 -> FFFFFF; x=7 -> 000000; x=2 -> 00FFFF; tp_rgb=0 during blanking.
